// File: rtl/mem_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mem_arb_pkg
// Description : Shared types and constants for the core-to-memory bus
//               arbiter: FSM state and grant encodings, the bus request
//               bundle, and access-size codes (log2 of the byte count).
// Revision    : 1.0 - initial release
// ============================================================================
package mem_arb_pkg;

    // Arbiter FSM states
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2
    } arb_state_t;

    // Owner of the current bus transaction
    typedef enum logic {
        GRANT_I = 1'b0,
        GRANT_D = 1'b1
    } grant_t;

    // Access size codes, log2 of the byte count
    localparam logic [2:0] MSIZE_1 = 3'd0;
    localparam logic [2:0] MSIZE_2 = 3'd1;
    localparam logic [2:0] MSIZE_4 = 3'd2;
    localparam logic [2:0] MSIZE_8 = 3'd3;

    // Width of the bus bundle at the default configuration
    localparam int BUS_ADDR_W = 64;
    localparam int BUS_DATA_W = 64;

    // One bus request as carried on the core-to-memory port
    typedef struct packed {
        logic                    write;
        logic [BUS_ADDR_W-1:0]   addr;
        logic [2:0]              size;
        logic [BUS_DATA_W/8-1:0] strobe;
        logic [BUS_DATA_W-1:0]   wdata;
    } bus_req_t;

endpackage
`default_nettype wire

// File: rtl/mem_arb_intf.sv
`default_nettype none
// ============================================================================
// Module      : mem_arb_intf
// Description : Signal bundle around mem_arbiter. Modports:
//                 fetch   - instruction requester (drives ireq_*)
//                 memory  - data requester (drives dreq_*)
//                 arbiter - the mem_arbiter side of every group
//                 bus     - the bus bridge (accepts breq_*, returns bresp_*)
// Revision    : 1.0 - initial release
// ============================================================================
interface mem_arb_intf #(
    parameter int ADDR_W = 64,
    parameter int DATA_W = 64
);
    // Fetch requester
    logic                  ireq_valid;
    logic [ADDR_W-1:0]     ireq_addr;
    logic                  iresp_ok;
    logic [DATA_W-1:0]     iresp_data;
    // Memory-stage requester
    logic                  dreq_valid;
    logic                  dreq_write;
    logic [ADDR_W-1:0]     dreq_addr;
    logic [2:0]            dreq_size;
    logic [DATA_W/8-1:0]   dreq_strobe;
    logic [DATA_W-1:0]     dreq_wdata;
    logic                  dresp_ok;
    logic [DATA_W-1:0]     dresp_data;
    // Bus side
    logic                  breq_valid;
    logic                  breq_ready;
    logic                  breq_write;
    logic [ADDR_W-1:0]     breq_addr;
    logic [2:0]            breq_size;
    logic [DATA_W/8-1:0]   breq_strobe;
    logic [DATA_W-1:0]     breq_wdata;
    logic                  bresp_valid;
    logic [DATA_W-1:0]     bresp_data;

    modport fetch (
        output ireq_valid, ireq_addr,
        input  iresp_ok, iresp_data
    );

    modport memory (
        output dreq_valid, dreq_write, dreq_addr, dreq_size, dreq_strobe, dreq_wdata,
        input  dresp_ok, dresp_data
    );

    modport arbiter (
        input  ireq_valid, ireq_addr,
        output iresp_ok, iresp_data,
        input  dreq_valid, dreq_write, dreq_addr, dreq_size, dreq_strobe, dreq_wdata,
        output dresp_ok, dresp_data,
        output breq_valid, breq_write, breq_addr, breq_size, breq_strobe, breq_wdata,
        input  breq_ready, bresp_valid, bresp_data
    );

    modport bus (
        input  breq_valid, breq_write, breq_addr, breq_size, breq_strobe, breq_wdata,
        output breq_ready, bresp_valid, bresp_data
    );

endinterface
`default_nettype wire

// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : mem_arbiter
// Description : Shares the single core-to-memory bus port between the fetch
//               stage (I) and the memory stage (D). The winning request is
//               latched, presented on the bus with a valid/ready handshake,
//               and the bus response is routed back to the winner as a
//               one-cycle ok pulse. One transaction outstanding at a time.
//               D has priority over I.
// Options     : MEM_ARB_STARVE_GUARD_EN - after STARVE_LIMIT consecutive D
//               grants made while I was waiting, the next contested
//               arbitration goes to I.
// Ports       : clk, reset (async, active-high)
//               ireq_*  / iresp_*  fetch request / response
//               dreq_*  / dresp_*  memory-stage request / response
//               breq_*  / bresp_*  bus request (valid/ready) / response
// Revision    : 1.0 - initial release
// ============================================================================
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W       = 64,
    parameter int DATA_W       = 64,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                clk,
    input  logic                reset,
    // Fetch requester
    input  logic                ireq_valid,
    input  logic [ADDR_W-1:0]   ireq_addr,
    output logic                iresp_ok,
    output logic [DATA_W-1:0]   iresp_data,
    // Memory-stage requester
    input  logic                dreq_valid,
    input  logic                dreq_write,
    input  logic [ADDR_W-1:0]   dreq_addr,
    input  logic [2:0]          dreq_size,
    input  logic [DATA_W/8-1:0] dreq_strobe,
    input  logic [DATA_W-1:0]   dreq_wdata,
    output logic                dresp_ok,
    output logic [DATA_W-1:0]   dresp_data,
    // Bus
    output logic                breq_valid,
    input  logic                breq_ready,
    output logic                breq_write,
    output logic [ADDR_W-1:0]   breq_addr,
    output logic [2:0]          breq_size,
    output logic [DATA_W/8-1:0] breq_strobe,
    output logic [DATA_W-1:0]   breq_wdata,
    input  logic                bresp_valid,
    input  logic [DATA_W-1:0]   bresp_data
);

    if (STARVE_LIMIT < 1) begin : g_starveLimitCheck
        $error("mem_arbiter: STARVE_LIMIT must be at least 1");
    end

    arb_state_t          r_state;
    grant_t              r_grant;
    logic                r_breqValid;
    logic                r_breqWrite;
    logic [ADDR_W-1:0]   r_breqAddr;
    logic [2:0]          r_breqSize;
    logic [DATA_W/8-1:0] r_breqStrobe;
    logic [DATA_W-1:0]   r_breqWdata;

    logic w_anyReq;
    logic w_forceI;
    logic w_grantI;
    logic w_respFire;

    assign w_anyReq = ireq_valid || dreq_valid;
    // I wins only when D is absent, or when the starvation guard forces it.
    assign w_grantI = ireq_valid && (!dreq_valid || w_forceI);

`ifdef MEM_ARB_STARVE_GUARD_EN
    localparam int c_CNT_W = $clog2(STARVE_LIMIT + 1);

    logic [c_CNT_W-1:0] r_starveCnt;

    assign w_forceI = (r_starveCnt == c_CNT_W'(STARVE_LIMIT));

    // Counts D grants that overtook a waiting I; any I grant clears it.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_starveCnt <= '0;
        end else if (r_state == IDLE && w_anyReq) begin
            if (w_grantI) begin
                r_starveCnt <= '0;
            end else if (ireq_valid && !w_forceI) begin
                r_starveCnt <= r_starveCnt + c_CNT_W'(1);
            end
        end
    end
`else
    assign w_forceI = 1'b0;
`endif

    // Arbitration FSM. The bus request fields come only from the registers
    // below, so they hold steady through any amount of backpressure.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= IDLE;
            r_grant      <= GRANT_I;
            r_breqValid  <= 1'b0;
            r_breqWrite  <= 1'b0;
            r_breqAddr   <= '0;
            r_breqSize   <= '0;
            r_breqStrobe <= '0;
            r_breqWdata  <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_anyReq) begin
                        r_state     <= REQ;
                        r_breqValid <= 1'b1;
                        if (w_grantI) begin
                            r_grant      <= GRANT_I;
                            r_breqWrite  <= 1'b0;
                            r_breqAddr   <= ireq_addr;
                            r_breqSize   <= MSIZE_8;
                            r_breqStrobe <= '0;
                            r_breqWdata  <= '0;
                        end else begin
                            r_grant      <= GRANT_D;
                            r_breqWrite  <= dreq_write;
                            r_breqAddr   <= dreq_addr;
                            r_breqSize   <= dreq_size;
                            r_breqStrobe <= dreq_strobe;
                            r_breqWdata  <= dreq_wdata;
                        end
                    end
                end
                REQ: begin
                    if (breq_ready) begin
                        r_state     <= WAIT;
                        r_breqValid <= 1'b0;
                    end
                end
                WAIT: begin
                    if (bresp_valid) begin
                        r_state <= IDLE;
                    end
                end
                default: begin
                    r_state     <= IDLE;
                    r_breqValid <= 1'b0;
                end
            endcase
        end
    end

    // Response routing is combinational so the ok lands in the same cycle as
    // bresp_valid; data is zeroed outside the pulse to keep idle outputs quiet.
    assign w_respFire = (r_state == WAIT) && bresp_valid;
    assign iresp_ok   = w_respFire && (r_grant == GRANT_I);
    assign dresp_ok   = w_respFire && (r_grant == GRANT_D);
    assign iresp_data = iresp_ok ? bresp_data : '0;
    assign dresp_data = dresp_ok ? bresp_data : '0;

    assign breq_valid  = r_breqValid;
    assign breq_write  = r_breqWrite;
    assign breq_addr   = r_breqAddr;
    assign breq_size   = r_breqSize;
    assign breq_strobe = r_breqStrobe;
    assign breq_wdata  = r_breqWdata;

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_arbiter
// Description : Self-checking bench for mem_arbiter. A bus model answers
//               requests with address-derived data; expected responses are
//               queued when requests are issued and popped on each ok pulse.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_arbiter;
    import mem_arb_pkg::*;

    localparam int ADDR_W       = 64;
    localparam int DATA_W       = 64;
    localparam int STARVE_LIMIT = 4;

    logic                clk;
    logic                reset;
    logic                ireq_valid;
    logic [ADDR_W-1:0]   ireq_addr;
    logic                iresp_ok;
    logic [DATA_W-1:0]   iresp_data;
    logic                dreq_valid;
    logic                dreq_write;
    logic [ADDR_W-1:0]   dreq_addr;
    logic [2:0]          dreq_size;
    logic [DATA_W/8-1:0] dreq_strobe;
    logic [DATA_W-1:0]   dreq_wdata;
    logic                dresp_ok;
    logic [DATA_W-1:0]   dresp_data;
    logic                breq_valid;
    logic                breq_ready;
    logic                breq_write;
    logic [ADDR_W-1:0]   breq_addr;
    logic [2:0]          breq_size;
    logic [DATA_W/8-1:0] breq_strobe;
    logic [DATA_W-1:0]   breq_wdata;
    logic                bresp_valid;
    logic [DATA_W-1:0]   bresp_data;

    mem_arbiter #(
        .ADDR_W       (ADDR_W),
        .DATA_W       (DATA_W),
        .STARVE_LIMIT (STARVE_LIMIT)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .ireq_valid  (ireq_valid),
        .ireq_addr   (ireq_addr),
        .iresp_ok    (iresp_ok),
        .iresp_data  (iresp_data),
        .dreq_valid  (dreq_valid),
        .dreq_write  (dreq_write),
        .dreq_addr   (dreq_addr),
        .dreq_size   (dreq_size),
        .dreq_strobe (dreq_strobe),
        .dreq_wdata  (dreq_wdata),
        .dresp_ok    (dresp_ok),
        .dresp_data  (dresp_data),
        .breq_valid  (breq_valid),
        .breq_ready  (breq_ready),
        .breq_write  (breq_write),
        .breq_addr   (breq_addr),
        .breq_size   (breq_size),
        .breq_strobe (breq_strobe),
        .breq_wdata  (breq_wdata),
        .bresp_valid (bresp_valid),
        .bresp_data  (bresp_data)
    );

    typedef struct {
        bit          isD;
        bit          isStore;
        logic [63:0] data;
    } exp_t;

    typedef struct {
        logic        write;
        logic [63:0] addr;
        logic [2:0]  size;
        logic [7:0]  strobe;
        logic [63:0] wdata;
    } busRec_t;

    exp_t    expQ[$];
    busRec_t busLog[$];

    int nCompared   = 0;
    int nMismatched = 0;
    int iOkCnt      = 0;
    int dOkCnt      = 0;
    int iRemaining  = 0;
    int dRemaining  = 0;
    int readyDelay  = 0;
    int respDelay   = 2;
    bit busEn       = 1'b1;

    // Bus contents: fixed instruction at the reset vector, otherwise a
    // pattern derived from the address.
    function automatic logic [63:0] busData(input logic [63:0] a);
        if (a == 64'h8000_0000) return 64'h13;
        return a ^ 64'h5A5A_0000_0000_0000;
    endfunction

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Bus bridge model: drives just after the rising edge.
    initial begin : busModel
        int phase;
        int waitCnt;
        int cnt;
        logic [63:0] curAddr;
        phase = 0; waitCnt = 0; cnt = 0; curAddr = '0;
        breq_ready = 1'b0; bresp_valid = 1'b0; bresp_data = '0;
        forever begin
            @(posedge clk); #1;
            if (reset || !busEn) begin
                if (reset) begin
                    breq_ready = 1'b0; bresp_valid = 1'b0; bresp_data = '0;
                end
                phase = 0; waitCnt = 0; cnt = 0;
            end else begin
                case (phase)
                    0: begin
                        if (breq_valid) begin
                            if (waitCnt == 0) begin
                                busLog.push_back('{breq_write, breq_addr, breq_size, breq_strobe, breq_wdata});
                                curAddr = breq_addr;
                            end
                            if (waitCnt >= readyDelay) begin
                                breq_ready = 1'b1; phase = 1; cnt = 1;
                            end else begin
                                breq_ready = 1'b0; waitCnt++;
                            end
                        end else begin
                            breq_ready = 1'b0;
                        end
                    end
                    1: begin
                        breq_ready = 1'b0;
                        if (cnt >= respDelay) begin
                            bresp_valid = 1'b1; bresp_data = busData(curAddr); phase = 2;
                        end else begin
                            cnt++;
                        end
                    end
                    default: begin
                        bresp_valid = 1'b0; bresp_data = '0; phase = 0; waitCnt = 0;
                    end
                endcase
            end
        end
    end

    // Response monitor and requester behaviour: each ok pops the scoreboard,
    // and the requester drops valid once its remaining count is used up.
    initial begin : monitor
        exp_t e;
        logic [63:0] got;
        forever begin
            @(negedge clk);
            if (iresp_ok && dresp_ok) begin
                nCompared++; nMismatched++;
                $display("FAIL both_ok: iresp_ok=1 dresp_ok=1 required at most one");
            end
            if (iresp_ok || dresp_ok) begin
                if (iresp_ok) iOkCnt++;
                if (dresp_ok) dOkCnt++;
                nCompared++;
                if (expQ.size() == 0) begin
                    nMismatched++;
                    $display("FAIL unexpected_ok: iresp_ok=%0b dresp_ok=%0b required no pulse", iresp_ok, dresp_ok);
                end else begin
                    e = expQ.pop_front();
                    got = e.isD ? dresp_data : iresp_data;
                    if (dresp_ok !== e.isD) begin
                        nMismatched++;
                        $display("FAIL resp_owner: dresp_ok=%0b required %0b", dresp_ok, e.isD);
                    end else if (!e.isStore && got !== e.data) begin
                        nMismatched++;
                        $display("FAIL resp_data: got 0x%016h required 0x%016h", got, e.data);
                    end
                end
                if (iresp_ok) begin
                    if (iRemaining > 0) iRemaining--;
                    if (iRemaining == 0) ireq_valid = 1'b0;
                end
                if (dresp_ok) begin
                    if (dRemaining > 0) dRemaining--;
                    if (dRemaining == 0) dreq_valid = 1'b0;
                end
            end
        end
    end

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    task automatic waitDrain(input string name);
        bit done;
        done = 1'b0;
        for (int k = 0; k < 300; k++) begin
            @(negedge clk);
            if (expQ.size() == 0 && !ireq_valid && !dreq_valid) begin
                done = 1'b1;
                break;
            end
        end
        nCompared++;
        if (!done) begin
            nMismatched++;
            $display("FAIL %s_timeout: pending=%0d required 0", name, expQ.size());
            expQ.delete();
            ireq_valid = 1'b0; dreq_valid = 1'b0;
        end
        repeat (3) @(negedge clk);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        ireq_valid = 1'b0; ireq_addr = '0;
        dreq_valid = 1'b0; dreq_write = 1'b0; dreq_addr = '0;
        dreq_size = '0; dreq_strobe = '0; dreq_wdata = '0;
        repeat (3) @(negedge clk);
        nCompared++;
        if ({breq_valid, iresp_ok, dresp_ok} !== 3'b000) begin
            nMismatched++;
            $display("FAIL reset_ctrl: valid/iok/dok=%b required 000", {breq_valid, iresp_ok, dresp_ok});
        end
        nCompared++;
        if (breq_write !== 1'b0 || breq_addr !== '0 || breq_size !== 3'd0 || breq_strobe !== '0 || breq_wdata !== '0) begin
            nMismatched++;
            $display("FAIL reset_fields: addr=0x%0h size=%0d strobe=0x%0h required all 0", breq_addr, breq_size, breq_strobe);
        end
        nCompared++;
        if (iresp_data !== '0 || dresp_data !== '0) begin
            nMismatched++;
            $display("FAIL reset_rdata: i=0x%0h d=0x%0h required 0", iresp_data, dresp_data);
        end
        reset = 1'b0;
        repeat (2) @(negedge clk);
        nCompared++;
        if (breq_valid !== 1'b0) begin
            nMismatched++;
            $display("FAIL idle_no_req: breq_valid=%0b required 0", breq_valid);
        end
    endtask

    task automatic test_i_only();
        int i0, d0;
        busLog.delete(); readyDelay = 0; respDelay = 2;
        i0 = iOkCnt; d0 = dOkCnt;
        @(negedge clk);
        ireq_addr = 64'h8000_0000; ireq_valid = 1'b1; iRemaining = 1;
        expQ.push_back('{1'b0, 1'b0, 64'h13});
        waitDrain("i_only");
        nCompared++;
        if (busLog.size() != 1) begin
            nMismatched++;
            $display("FAIL i_only_bus_count: %0d required 1", busLog.size());
        end else begin
            nCompared++;
            if (busLog[0].addr !== 64'h8000_0000 || busLog[0].write !== 1'b0 ||
                busLog[0].size !== MSIZE_8 || busLog[0].strobe !== 8'h00) begin
                nMismatched++;
                $display("FAIL i_only_bus_fields: addr=0x%0h w=%0b size=%0d strobe=0x%0h required 0x80000000/0/3/0",
                         busLog[0].addr, busLog[0].write, busLog[0].size, busLog[0].strobe);
            end
        end
        nCompared++;
        if (iOkCnt - i0 != 1 || dOkCnt - d0 != 0) begin
            nMismatched++;
            $display("FAIL i_only_pulses: iok=%0d dok=%0d required 1/0", iOkCnt - i0, dOkCnt - d0);
        end
    endtask

    task automatic test_latency();
        int edges;
        bit seen;
        readyDelay = 0; respDelay = 1; seen = 1'b0; edges = 0;
        @(negedge clk);
        ireq_addr = 64'h8000_0000; ireq_valid = 1'b1; iRemaining = 1;
        expQ.push_back('{1'b0, 1'b0, 64'h13});
        for (int k = 0; k < 20; k++) begin
            @(posedge clk); edges++;
            @(negedge clk);
            if (iresp_ok) begin seen = 1'b1; break; end
        end
        // Latch edge, accept edge, then the ok in the third cycle.
        nCompared++;
        if (!seen || edges != 2) begin
            nMismatched++;
            $display("FAIL min_latency: edges=%0d seen=%0b required 2/1", edges, seen);
        end
        waitDrain("latency");
    endtask

    task automatic test_simultaneous();
        int i0, d0;
        busLog.delete(); readyDelay = 0; respDelay = 2;
        i0 = iOkCnt; d0 = dOkCnt;
        @(negedge clk);
        ireq_addr = 64'h8000_0004; ireq_valid = 1'b1; iRemaining = 1;
        dreq_addr = 64'h1000; dreq_write = 1'b0; dreq_size = MSIZE_8;
        dreq_strobe = 8'hFF; dreq_wdata = '0; dreq_valid = 1'b1; dRemaining = 1;
        expQ.push_back('{1'b1, 1'b0, busData(64'h1000)});
        expQ.push_back('{1'b0, 1'b0, busData(64'h8000_0004)});
        waitDrain("simul");
        nCompared++;
        if (busLog.size() != 2 || busLog[0].addr !== 64'h1000 || busLog[1].addr !== 64'h8000_0004) begin
            nMismatched++;
            $display("FAIL simul_bus_order: n=%0d first=0x%0h required 2 with 0x1000 then 0x80000004",
                     busLog.size(), (busLog.size() > 0) ? busLog[0].addr : 64'h0);
        end
        nCompared++;
        if (iOkCnt - i0 != 1 || dOkCnt - d0 != 1) begin
            nMismatched++;
            $display("FAIL simul_pulses: iok=%0d dok=%0d required 1/1", iOkCnt - i0, dOkCnt - d0);
        end
    endtask

    task automatic test_backpressure();
        int validCycles;
        busLog.delete(); readyDelay = 5; respDelay = 2; validCycles = 0;
        @(negedge clk);
        dreq_addr = 64'h2000; dreq_write = 1'b1; dreq_size = MSIZE_4;
        dreq_strobe = 8'h0F; dreq_wdata = 64'hDEAD_BEEF; dreq_valid = 1'b1; dRemaining = 1;
        expQ.push_back('{1'b1, 1'b1, 64'h0});
        for (int k = 0; k < 30; k++) begin
            @(negedge clk);
            if (breq_valid) begin
                validCycles++;
                nCompared++;
                if (breq_addr !== 64'h2000 || breq_write !== 1'b1 || breq_size !== MSIZE_4 ||
                    breq_strobe !== 8'h0F || breq_wdata !== 64'hDEAD_BEEF) begin
                    nMismatched++;
                    $display("FAIL bp_fields: addr=0x%0h w=%0b size=%0d strobe=0x%0h wdata=0x%0h required 0x2000/1/2/0x0f/0xdeadbeef",
                             breq_addr, breq_write, breq_size, breq_strobe, breq_wdata);
                end
            end else if (validCycles > 0) begin
                break;
            end
        end
        nCompared++;
        if (validCycles != 6) begin
            nMismatched++;
            $display("FAIL bp_valid_cycles: %0d required 6", validCycles);
        end
        waitDrain("backpressure");
        readyDelay = 0;
    endtask

    task automatic test_spurious();
        int i0, d0;
        i0 = iOkCnt; d0 = dOkCnt;
        busEn = 1'b0;
        @(negedge clk);
        breq_ready = 1'b0; bresp_valid = 1'b1; bresp_data = 64'hBAD0_BAD0;
        repeat (3) begin
            @(negedge clk);
            nCompared++;
            if (breq_valid !== 1'b0 || iresp_ok !== 1'b0 || dresp_ok !== 1'b0) begin
                nMismatched++;
                $display("FAIL spur_idle: valid/iok/dok=%b required 000", {breq_valid, iresp_ok, dresp_ok});
            end
        end
        dreq_addr = 64'h4000; dreq_write = 1'b0; dreq_size = MSIZE_8;
        dreq_strobe = 8'hFF; dreq_valid = 1'b1; dRemaining = 1;
        expQ.push_back('{1'b1, 1'b0, busData(64'h4000)});
        repeat (3) begin
            @(negedge clk);
            nCompared++;
            if (breq_valid !== 1'b1 || breq_addr !== 64'h4000 || iresp_ok !== 1'b0 || dresp_ok !== 1'b0) begin
                nMismatched++;
                $display("FAIL spur_req: valid=%0b addr=0x%0h iok=%0b dok=%0b required 1/0x4000/0/0",
                         breq_valid, breq_addr, iresp_ok, dresp_ok);
            end
        end
        bresp_valid = 1'b0; bresp_data = '0;
        busEn = 1'b1;
        waitDrain("spurious");
        nCompared++;
        if (iOkCnt - i0 != 0 || dOkCnt - d0 != 1) begin
            nMismatched++;
            $display("FAIL spur_pulses: iok=%0d dok=%0d required 0/1", iOkCnt - i0, dOkCnt - d0);
        end
    endtask

    task automatic test_starve();
        int iPos;
        busLog.delete(); readyDelay = 0; respDelay = 1;
`ifdef MEM_ARB_STARVE_GUARD_EN
        iPos = 4;
`else
        iPos = 6;
`endif
        @(negedge clk);
        dreq_addr = 64'h3000; dreq_write = 1'b0; dreq_size = MSIZE_8;
        dreq_strobe = 8'hFF; dreq_valid = 1'b1; dRemaining = 6;
        ireq_addr = 64'h8000_0008; ireq_valid = 1'b1; iRemaining = 1;
        for (int k = 0; k < 7; k++) begin
            if (k == iPos) expQ.push_back('{1'b0, 1'b0, busData(64'h8000_0008)});
            else           expQ.push_back('{1'b1, 1'b0, busData(64'h3000)});
        end
        waitDrain("starve");
        nCompared++;
        if (busLog.size() != 7) begin
            nMismatched++;
            $display("FAIL starve_bus_count: %0d required 7", busLog.size());
        end else begin
            nCompared++;
            if (busLog[iPos].addr !== 64'h8000_0008) begin
                nMismatched++;
                $display("FAIL starve_i_slot: slot %0d addr=0x%0h required 0x80000008", iPos, busLog[iPos].addr);
            end
        end
    endtask

    task automatic test_reset_in_wait();
        bit seen;
        seen = 1'b0; readyDelay = 0; respDelay = 2;
        @(negedge clk);
        ireq_addr = 64'h8000_0010; ireq_valid = 1'b1; iRemaining = 1;
        expQ.push_back('{1'b0, 1'b0, busData(64'h8000_0010)});
        for (int k = 0; k < 20; k++) begin
            @(posedge clk); #2;
            if (iresp_ok) begin seen = 1'b1; break; end
        end
        nCompared++;
        if (!seen) begin
            nMismatched++;
            $display("FAIL rst_wait_reach: iresp_ok never rose, required 1");
        end
        reset = 1'b1;
        #1;
        nCompared++;
        if ({breq_valid, iresp_ok, dresp_ok} !== 3'b000 || iresp_data !== '0) begin
            nMismatched++;
            $display("FAIL rst_async: valid/iok/dok=%b idata=0x%0h required 000/0",
                     {breq_valid, iresp_ok, dresp_ok}, iresp_data);
        end
        ireq_valid = 1'b0; iRemaining = 0;
        expQ.delete();
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        ireq_addr = 64'h8000_0020; ireq_valid = 1'b1; iRemaining = 1;
        expQ.push_back('{1'b0, 1'b0, busData(64'h8000_0020)});
        waitDrain("post_reset");
    endtask

    initial begin : main
        test_reset();
        test_i_only();
        test_latency();
        test_simultaneous();
        test_backpressure();
        test_spurious();
        test_starve();
        test_reset_in_wait();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares the single core-to-memory bus port between the fetch stage (instruction requester, I) and the memory stage (data requester, D).
- Latches the winning request, drives it onto the bus with a valid/ready handshake, waits for the bus response and routes it back to the winner.
- Sits between fetch/memory and the bus bridge. Hazard logic stalls a stage while its response is pending.

Parameters:
- ADDR_W, 64, address width of requests and bus.
- DATA_W, 64, read/write data width.
- STARVE_LIMIT, 4, consecutive D grants with I pending before I is forced (used only with the optional feature).

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- ireq_valid  in  1  fetch request; held until iresp_ok
- ireq_addr  in  ADDR_W  fetch address
- iresp_ok  out  1  one-cycle pulse: instruction data valid
- iresp_data  out  DATA_W  fetched data
- dreq_valid  in  1  data request; held until dresp_ok
- dreq_write  in  1  1 = store
- dreq_addr  in  ADDR_W  data address
- dreq_size  in  3  log2 bytes, 0..3
- dreq_strobe  in  DATA_W/8  byte enables for stores
- dreq_wdata  in  DATA_W  store data
- dresp_ok  out  1  one-cycle pulse: data access done
- dresp_data  out  DATA_W  load data
- breq_valid  out  1  bus request valid
- breq_ready  in  1  bus accepts request
- breq_write, breq_addr, breq_size, breq_strobe, breq_wdata  out  1/ADDR_W/3/DATA_W/8/DATA_W  bus request fields
- bresp_valid  in  1  bus response valid
- bresp_data  in  DATA_W  bus read data

Behaviour:
- Reset values:
  - State IDLE.
  - breq_valid, iresp_ok, dresp_ok = 0.
  - All breq_* fields, iresp_data and dresp_data = 0.
  - Grant register = I.
  - Starve counter = 0.
- FSM states: IDLE, REQ, WAIT.
- IDLE:
  - If any request is valid, latch the winner's fields into the request register, record the grant (I or D), go to REQ next cycle.
  - Priority is D over I. Simultaneous I and D in IDLE means D wins.
- REQ:
  - breq_valid = 1 and breq_* are driven only from the registered request, never combinationally from the inputs.
  - When breq_valid && breq_ready, go to WAIT. Otherwise hold; fields stay stable.
  - I requests always drive breq_write = 0, breq_size = 3, breq_strobe = 0.
- WAIT:
  - breq_valid = 0.
  - On bresp_valid, pulse iresp_ok or dresp_ok (per grant) in the same cycle, with *resp_data = bresp_data combinationally; return to IDLE.
  - Store responses also pulse dresp_ok; dresp_data is don't-care.
- bresp_valid outside WAIT is ignored. The bus never responds in its accept cycle.
- Minimum latency, request to ok: 3 cycles (IDLE latch, REQ accept, WAIT response).
- A requester valid seen in IDLE in the cycle after its ok is a new request.
- A requester deasserting valid mid-transaction does not abort it. The ok still pulses and the requester ignores it.
- Only one transaction is outstanding at a time. No pipelining across requesters.
- reset asserted in any state returns to IDLE immediately. An in-flight bus transaction is abandoned; the bus bridge shares the same reset.

Optional Feature:
- Macro: MEM_ARB_STARVE_GUARD_EN.
- When defined:
  - A counter increments on each D grant made while ireq_valid = 1, and clears on any I grant.
  - When the counter equals STARVE_LIMIT and both requests are valid in IDLE, I wins.
- When undefined: strict D priority; no counter is instantiated.

Decomposition:
- New package mem_arb_pkg:
  - arb_state_t enum (IDLE, REQ, WAIT).
  - grant_t enum (GRANT_I, GRANT_D).
  - bus_req_t struct (write, addr, size, strobe, wdata).
  - Size constants MSIZE_1/2/4/8.
- Export mem_arbiter through a new mem_arb_intf in interface.svh, with modports fetch, memory, arbiter and bus.
- Single module; no sub-module (the starve counter is a few lines inside the `ifdef).

Test Plan:
- I only: ireq addr 0x8000_0000; bus ready immediately, responds 2 cycles later with 0x13 -> breq_addr 0x8000_0000, breq_write 0, iresp_ok one cycle, iresp_data 0x13, dresp_ok never.
- Simultaneous I 0x8000_0004 and D load 0x1000 -> bus sees 0x1000 first, then 0x8000_0004. dresp_ok precedes iresp_ok; exactly one pulse each.
- Backpressure: D store addr 0x2000, strobe 0x0F, wdata 0xDEAD_BEEF; breq_ready low 5 cycles -> breq_* constant across all 6 valid cycles, then dresp_ok on response.
- Spurious bresp_valid in IDLE/REQ -> no ok pulse, no state change.
- Reset asserted in WAIT -> breq_valid and oks low asynchronously. After release, a fresh I request completes normally.
- With MEM_ARB_STARVE_GUARD_EN and STARVE_LIMIT 4: I held while D requests back-to-back -> the 5th grant goes to I. Without the macro, I waits until D drops.
